udp_pkt_gen: RTL and testbench

Traffic-source packet generator for the 40G UDP path. On a start command it emits a configurable number of fixed-length payload packets, with a programmable inter-packet gap, as a 512-bit fragment stream. The stream connects directly to the `io_dataIn_*` port of `EthernetTx`, in the `pkt_clk` domain. Running packet and byte counters are exposed for ILA/VIO observation.

---
 rtl/udp_pkt_gen_pkg.sv | 19 +
 rtl/udp_pkt_gen_beat.sv | 26 ++
 rtl/udp_pkt_gen.sv | 151 +++++++++++++++
 tb/tb_udp_pkt_gen.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_pkt_gen_pkg.sv
// Shared widths, FSM state type and keep-mask helper for the UDP packet generator.
package udp_pkt_gen_pkg;

  localparam int DATA_W = 512;
  localparam int KEEP_W = DATA_W / 8;
  localparam int LEN_W  = 16;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  // Contiguous mask with the low 'bytes' bits set (bytes >= KEEP_W gives all ones).
  function automatic logic [KEEP_W-1:0] len2keep(input logic [LEN_W-1:0] bytes);
    logic [KEEP_W-1:0] keep;
    for (int i = 0; i < KEEP_W; i++) begin
      keep[i] = (LEN_W'(i) < bytes);
    end
    return keep;
  endfunction

endpackage

// File: rtl/udp_pkt_gen_beat.sv
// Combinational beat formatter: byte count, keep mask, last flag and ramp payload
// for the beat that starts with 'remain' bytes left in the packet.
module udp_pkt_gen_beat
  import udp_pkt_gen_pkg::*;
(
  input  logic [LEN_W-1:0]  remain,
  input  logic [1:0]        beat_idx,
  output logic [LEN_W-1:0]  byte_num,
  output logic [KEEP_W-1:0] tkeep,
  output logic              last,
  output logic [DATA_W-1:0] data
);

  assign last     = (remain <= LEN_W'(KEEP_W));
  assign byte_num = last ? remain : LEN_W'(KEEP_W);
  assign tkeep    = len2keep(byte_num);

  // Packet offset mod 256 is {beat index mod 4, byte lane}, so two beat bits suffice.
  genvar gi;
  generate
    for (gi = 0; gi < KEEP_W; gi++) begin : g_ramp
      assign data[gi*8 +: 8] = {beat_idx, 6'(gi)};
    end
  endgenerate

endmodule

// File: rtl/udp_pkt_gen.sv
// Fixed-length UDP payload packet generator with inter-packet gap and run counters.
// Optional: define UDP_PKT_GEN_SEQ_EN to overlay a big-endian sequence number on bytes 0..3.
module udp_pkt_gen
  import udp_pkt_gen_pkg::*;
(
  input  logic              clk,
  input  logic              aresetn,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [LEN_W-1:0]  cfg_pkt_len,
  input  logic [31:0]       cfg_pkt_cnt,
  input  logic [LEN_W-1:0]  cfg_gap,
  output logic              busy,
  output logic              done,
  output logic [31:0]       tx_pkt_count,
  output logic [47:0]       tx_byte_count,
  output logic              io_dataOut_valid,
  input  logic              io_dataOut_ready,
  output logic              io_dataOut_payload_last,
  output logic [DATA_W-1:0] io_dataOut_payload_fragment_data,
  output logic [LEN_W-1:0]  io_dataOut_payload_fragment_byteNum,
  output logic [KEEP_W-1:0] io_dataOut_payload_fragment_tkeep
);

  state_t             state_reg, state_next;
  logic [LEN_W-1:0]   len_reg, gap_reg, gap_cnt_reg, remain_reg;
  logic [31:0]        cnt_reg, pkt_count_reg, pkt_count_inc;
  logic [47:0]        byte_count_reg;
  logic [1:0]         beat_idx_reg;
  logic               stop_reg, done_reg;
  logic               send, hs, last_hs, stop_req, run_end;
  logic [LEN_W-1:0]   beat_bytes;
  logic [KEEP_W-1:0]  beat_keep;
  logic               beat_last;
  logic [DATA_W-1:0]  beat_data, pay_data;

  udp_pkt_gen_beat u_beat (
    .remain   (remain_reg),
    .beat_idx (beat_idx_reg),
    .byte_num (beat_bytes),
    .tkeep    (beat_keep),
    .last     (beat_last),
    .data     (beat_data)
  );

  assign send          = (state_reg == SEND);
  assign hs            = send && io_dataOut_ready;
  assign last_hs       = hs && beat_last;
  assign stop_req      = stop_reg || cfg_stop;
  assign pkt_count_inc = pkt_count_reg + 32'd1;
  assign run_end       = stop_req || ((cnt_reg != 32'd0) && (pkt_count_inc == cnt_reg));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (cfg_start) state_next = SEND;
      SEND: begin
        if (last_hs) begin
          if (run_end)                    state_next = IDLE;
          else if (gap_reg == '0)         state_next = SEND;
          else                            state_next = GAP;
        end
      end
      GAP: begin
        if (stop_req)                                  state_next = IDLE;
        else if (gap_cnt_reg == gap_reg - LEN_W'(1))   state_next = SEND;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      len_reg        <= '0;
      gap_reg        <= '0;
      cnt_reg        <= '0;
      gap_cnt_reg    <= '0;
      remain_reg     <= '0;
      beat_idx_reg   <= '0;
      pkt_count_reg  <= '0;
      byte_count_reg <= '0;
      stop_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg    <= (state_reg != IDLE) && (state_next == IDLE);
      stop_reg    <= (state_next == IDLE) ? 1'b0 : stop_req;
      gap_cnt_reg <= (state_reg == GAP) ? gap_cnt_reg + LEN_W'(1) : '0;
      if ((state_reg == IDLE) && cfg_start) begin
        // A zero length is promoted to one byte so every packet has a last beat.
        len_reg        <= (cfg_pkt_len == '0) ? LEN_W'(1) : cfg_pkt_len;
        remain_reg     <= (cfg_pkt_len == '0) ? LEN_W'(1) : cfg_pkt_len;
        gap_reg        <= cfg_gap;
        cnt_reg        <= cfg_pkt_cnt;
        beat_idx_reg   <= '0;
        pkt_count_reg  <= '0;
        byte_count_reg <= '0;
      end else if (hs) begin
        byte_count_reg <= byte_count_reg + 48'(beat_bytes);
        if (beat_last) begin
          remain_reg    <= len_reg;
          beat_idx_reg  <= '0;
          pkt_count_reg <= pkt_count_inc;
        end else begin
          remain_reg   <= remain_reg - LEN_W'(KEEP_W);
          beat_idx_reg <= beat_idx_reg + 2'd1;
        end
      end
    end
  end

`ifdef UDP_PKT_GEN_SEQ_EN
  logic [31:0] seq_reg;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)                           seq_reg <= '0;
    else if ((state_reg == IDLE) && cfg_start) seq_reg <= '0;
    else if (last_hs)                       seq_reg <= seq_reg + 32'd1;
  end

  // Only the first beat of a packet carries the sequence number, and only in valid lanes.
  always_comb begin
    pay_data = beat_data;
    if (remain_reg == len_reg) begin
      for (int b = 0; b < 4; b++) begin
        if (beat_keep[b]) pay_data[b*8 +: 8] = seq_reg[31-b*8 -: 8];
      end
    end
  end
`else
  assign pay_data = beat_data;
`endif

  always_comb begin
    busy                                = (state_reg != IDLE);
    io_dataOut_valid                    = send;
    io_dataOut_payload_last             = send && beat_last;
    io_dataOut_payload_fragment_data    = send ? pay_data : '0;
    io_dataOut_payload_fragment_byteNum = send ? beat_bytes : '0;
    io_dataOut_payload_fragment_tkeep   = send ? beat_keep : '0;
  end

  assign done          = done_reg;
  assign tx_pkt_count  = pkt_count_reg;
  assign tx_byte_count = byte_count_reg;

endmodule

// File: tb/tb_udp_pkt_gen.sv
// Self-checking bench for udp_pkt_gen: per-cycle behavioural model plus directed literal checks.
module tb_udp_pkt_gen;

  logic         clk = 1'b0;
  logic         aresetn;
  logic         cfg_start, cfg_stop;
  logic [15:0]  cfg_pkt_len, cfg_gap;
  logic [31:0]  cfg_pkt_cnt;
  logic         busy, done;
  logic [31:0]  tx_pkt_count;
  logic [47:0]  tx_byte_count;
  logic         valid, ready, last;
  logic [511:0] data;
  logic [15:0]  byte_num;
  logic [63:0]  tkeep;

  udp_pkt_gen dut (
    .clk                                 (clk),
    .aresetn                             (aresetn),
    .cfg_start                           (cfg_start),
    .cfg_stop                            (cfg_stop),
    .cfg_pkt_len                         (cfg_pkt_len),
    .cfg_pkt_cnt                         (cfg_pkt_cnt),
    .cfg_gap                             (cfg_gap),
    .busy                                (busy),
    .done                                (done),
    .tx_pkt_count                        (tx_pkt_count),
    .tx_byte_count                       (tx_byte_count),
    .io_dataOut_valid                    (valid),
    .io_dataOut_ready                    (ready),
    .io_dataOut_payload_last             (last),
    .io_dataOut_payload_fragment_data    (data),
    .io_dataOut_payload_fragment_byteNum (byte_num),
    .io_dataOut_payload_fragment_tkeep   (tkeep)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  function automatic void chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Behavioural model state (what the outputs must be in the current cycle)
  logic        m_busy = 0, m_done = 0, m_stop = 0;
  logic [31:0] m_pkts = 0, m_cnt = 0, m_seq = 0;
  logic [47:0] m_bytes = 0;
  int          m_len = 1, m_gap = 0, m_off = 0, m_gap_left = 0;

  // Observation logs for the directed literal checks
  int          bn_log[$];
  logic [63:0] keep_log[$];
  logic        last_log[$];
  logic [31:0] head_log[$];
  int          idle_log[$];
  int          idle_run = 0;
  logic        dut_mid = 0, done_seen = 0;

  logic        stall_prev = 0;
  logic [511:0] prev_data;
  logic [15:0] prev_bn;
  logic [63:0] prev_keep;
  logic        prev_last;
  logic        rnd_ready = 0;

  always @(negedge clk) begin
    logic        was_busy, exp_valid, lst, done_next;
    int          rem, bn, k;
    logic [63:0] ek;
    logic [511:0] ed, mask;
    if (!aresetn) begin
      m_busy = 0; m_done = 0; m_stop = 0; m_pkts = 0; m_bytes = 0; m_seq = 0;
      m_off = 0; m_gap_left = 0; stall_prev = 0; dut_mid = 0; idle_run = 0;
    end else begin
      was_busy  = m_busy;
      exp_valid = m_busy && (m_gap_left == 0);
      chk("valid", valid, exp_valid);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("pkt_count", tx_pkt_count, m_pkts);
      chk("byte_count", tx_byte_count, m_bytes);
      if (stall_prev) begin
        chk("stall_valid", valid, 1'b1);
        chk("stall_data", data, prev_data);
        chk("stall_bytenum", byte_num, prev_bn);
        chk("stall_tkeep", tkeep, prev_keep);
        chk("stall_last", last, prev_last);
      end
      stall_prev = valid && !ready;
      prev_data = data; prev_bn = byte_num; prev_keep = tkeep; prev_last = last;

      // DUT-side observation logs
      if (done) done_seen = 1;
      if (busy && !valid) idle_run++;
      if (valid && ready) begin
        if (!dut_mid) begin
          idle_log.push_back(idle_run);
          head_log.push_back(data[31:0]);
          idle_run = 0;
        end
        bn_log.push_back(int'(byte_num));
        keep_log.push_back(tkeep);
        last_log.push_back(last);
        dut_mid = !last;
        $display("beat pkt=%0d bytes=%0d last=%0b head=%08h", tx_pkt_count, byte_num, last, data[31:0]);
      end

      // Expected beat from packet offset
      done_next = 0;
      rem = m_len - m_off;
      bn  = (rem > 64) ? 64 : rem;
      lst = (rem <= 64);
      if (exp_valid && valid) begin
        ek = '0; ed = '0; mask = '0;
        for (int i = 0; i < 64; i++) begin
          if (i < bn) begin
            k = m_off + i;
            ek[i] = 1'b1;
            mask[i*8 +: 8] = 8'hff;
            ed[i*8 +: 8] = 8'(k);
`ifdef UDP_PKT_GEN_SEQ_EN
            if (k < 4) ed[i*8 +: 8] = 8'(m_seq >> (8 * (3 - k)));
`endif
          end
        end
        chk("bytenum", byte_num, 16'(bn));
        chk("tkeep", tkeep, ek);
        chk("last", last, lst);
        chk("data", data & mask, ed);
      end

      // Advance model to next cycle
      if (m_busy && cfg_stop) m_stop = 1;
      if (exp_valid && ready) begin
        m_bytes = m_bytes + 48'(bn);
        m_off   = m_off + bn;
        if (lst) begin
          m_pkts = m_pkts + 1;
          m_seq  = m_seq + 1;
          m_off  = 0;
          if (m_stop || ((m_cnt != 0) && (m_pkts == m_cnt))) begin
            m_busy = 0; m_stop = 0; done_next = 1;
          end else begin
            m_gap_left = m_gap;
          end
        end
      end else if (m_busy && !exp_valid) begin
        if (m_stop) begin
          m_busy = 0; m_stop = 0; m_gap_left = 0; done_next = 1;
        end else begin
          m_gap_left--;
        end
      end
      if (!was_busy && cfg_start) begin
        m_busy = 1; m_stop = 0; m_pkts = 0; m_bytes = 0; m_seq = 0; m_off = 0; m_gap_left = 0;
        m_len = (cfg_pkt_len == 0) ? 1 : int'(cfg_pkt_len);
        m_cnt = cfg_pkt_cnt;
        m_gap = int'(cfg_gap);
        idle_run = 0; dut_mid = 0;
      end
      m_done = done_next;
    end
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (rnd_ready) ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic start_run(input int len, input int cnt, input int gap);
    bn_log.delete(); keep_log.delete(); last_log.delete(); head_log.delete(); idle_log.delete();
    done_seen   = 0;
    cfg_pkt_len = 16'(len);
    cfg_pkt_cnt = 32'(cnt);
    cfg_gap     = 16'(gap);
    cfg_start   = 1;
    cyc();
    cfg_start   = 0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (!done_seen && n < budget) begin
      cyc();
      n++;
    end
    chk(nm, done_seen, 1'b1);
  endtask

  initial begin
    int maxidle;
    logic [31:0] exp_head;
    aresetn = 0; cfg_start = 0; cfg_stop = 0; ready = 1;
    cfg_pkt_len = 0; cfg_pkt_cnt = 0; cfg_gap = 0;
    cyc(3);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pkts", tx_pkt_count, 32'd0);
    chk("rst_bytes", tx_byte_count, 48'd0);
    chk("rst_data", data, 512'd0);
    chk("rst_keep", tkeep, 64'd0);
    chk("rst_bytenum", byte_num, 16'd0);
    aresetn = 1;
    cyc(2);

    // Single 100-byte packet
    start_run(100, 1, 0);
    wait_done("t1_done", 20);
    chk("t1_nbeats", bn_log.size(), 2);
    chk("t1_b0_bytes", bn_log[0], 64);
    chk("t1_b0_keep", keep_log[0], 64'hFFFFFFFF_FFFFFFFF);
    chk("t1_b0_last", last_log[0], 1'b0);
    chk("t1_b1_bytes", bn_log[1], 36);
    chk("t1_b1_keep", keep_log[1], 64'h0000000F_FFFFFFFF);
    chk("t1_b1_last", last_log[1], 1'b1);
    cyc();
    chk("t1_pkts", tx_pkt_count, 32'd1);
    chk("t1_bytes", tx_byte_count, 48'd100);
    chk("t1_busy", busy, 1'b0);

    // Single-beat packets separated by a 5-cycle gap
    start_run(64, 3, 5);
    wait_done("t2_done", 60);
    chk("t2_nbeats", bn_log.size(), 3);
    for (int i = 0; i < 3; i++) chk("t2_last", last_log[i], 1'b1);
    chk("t2_gap1", idle_log[1], 5);
    chk("t2_gap2", idle_log[2], 5);
    cyc();
    chk("t2_bytes", tx_byte_count, 48'd192);

    // Random backpressure
    rnd_ready = 1;
    start_run(200, 10, 0);
    wait_done("t3_done", 400);
    rnd_ready = 0;
    ready = 1;
    cyc();
    chk("t3_pkts", tx_pkt_count, 32'd10);
    chk("t3_bytes", tx_byte_count, 48'd2000);

    // Continuous run, stop while packet 4 is in flight
    start_run(100, 0, 0);
    for (int n = 0; n < 50 && !(m_pkts >= 3 && m_off == 0); n++) cyc();
    cfg_stop = 1;
    cyc();
    cfg_stop = 0;
    wait_done("t4_done", 20);
    maxidle = 0;
    foreach (idle_log[i]) if (idle_log[i] > maxidle) maxidle = idle_log[i];
    chk("t4_no_bubble", maxidle, 0);
    chk("t4_final_last", last_log[last_log.size() - 1], 1'b1);
    cyc();
    chk("t4_pkts", tx_pkt_count, 32'd4);
    chk("t4_bytes", tx_byte_count, 48'd400);

    // Stop during the inter-packet gap
    start_run(64, 0, 20);
    for (int n = 0; n < 100 && !(m_pkts == 2 && !valid); n++) cyc();
    cyc(3);
    cfg_stop = 1;
    cyc();
    cfg_stop = 0;
    chk("t5_gap_stop_done", done, 1'b1);
    chk("t5_gap_stop_busy", busy, 1'b0);
    chk("t5_pkts", tx_pkt_count, 32'd2);
    chk("t5_bytes", tx_byte_count, 48'd128);
    cyc(2);

    // Zero length, start while busy ignored
    start_run(0, 2, 1);
    cyc();
    cfg_pkt_len = 16'd50; cfg_pkt_cnt = 32'd7; cfg_start = 1;
    cyc();
    cfg_start = 0;
    wait_done("t6_done", 20);
    chk("t6_nbeats", bn_log.size(), 2);
    chk("t6_bytes0", bn_log[0], 1);
    chk("t6_keep0", keep_log[0], 64'd1);
    chk("t6_last0", last_log[0], 1'b1);
    cyc();
    chk("t6_pkts", tx_pkt_count, 32'd2);
    chk("t6_bytecnt", tx_byte_count, 48'd2);

    // Asynchronous reset mid-packet
    start_run(300, 0, 0);
    cyc(2);
    aresetn = 0;
    #1;
    chk("t7_valid", valid, 1'b0);
    chk("t7_busy", busy, 1'b0);
    chk("t7_pkts", tx_pkt_count, 32'd0);
    chk("t7_bytes", tx_byte_count, 48'd0);
    cyc();
    aresetn = 1;
    cyc(2);

    // Packet heads: sequence number or ramp
    start_run(10, 3, 0);
    wait_done("t8_done", 30);
    chk("t8_npkts", head_log.size(), 3);
    for (int p = 0; p < 3; p++) begin
`ifdef UDP_PKT_GEN_SEQ_EN
      exp_head = {8'(p), 24'h0};
`else
      exp_head = 32'h03020100;
`endif
      chk("t8_head", head_log[p], exp_head);
    end
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
